cmos_capture_data: RTL and testbench

Camera capture front end in the `cam_pclk` domain. It sits between the OV5640 pins and the DDR3 write port.
- Drops the first frames after capture is enabled.
- Pairs the 8-bit DVP bytes into RGB565 pixels.
- Produces frame-aligned `cmos_frame_vsync`, `cmos_frame_href`, `cmos_frame_valid` and `cmos_frame_data` for the frame buffer write path.
- Reports the measured line width and frame height, for checking against the programmed camera resolution.

---
 rtl/cam_pkg.sv | 7 +
 rtl/sync_2ff.sv | 12 +
 rtl/cmos_capture_data.sv | 93 +++++++++
 tb/tb_cmos_capture_data.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// cam_pkg: shared types and widths for the camera capture path.
package cam_pkg;
   typedef enum logic [1:0] {IDLE, SKIP, RUN} cap_state_t;
   localparam int RGB565_W = 16;
   localparam int CAM_BYTE_W = 8;
   localparam int WAIT_FRAME_DEF = 10;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for a single-bit level from another clock domain.
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);
   logic meta;
   always_ff @(posedge clk or posedge rst)
      if (rst) {q, meta} <= 2'b00;
      else {q, meta} <= {meta, d};
endmodule

// File: rtl/cmos_capture_data.sv
// cmos_capture_data: OV5640 DVP capture with start-up frame skip, RGB565 byte pairing
// and line/frame size measurement, all in the cam_pclk domain.
module cmos_capture_data
   import cam_pkg::*;
#(
   parameter int WAIT_FRAME = WAIT_FRAME_DEF,
   parameter int CNT_W = 13
) (
   input  logic                  cam_pclk,
   input  logic                  rst,
   input  logic                  capture_start,
   input  logic                  cam_vsync,
   input  logic                  cam_href,
   input  logic [CAM_BYTE_W-1:0] cam_data,
   output logic                  cmos_frame_vsync,
   output logic                  cmos_frame_href,
   output logic                  cmos_frame_valid,
   output logic [RGB565_W-1:0]   cmos_frame_data,
   output logic [CNT_W-1:0]      line_pixels,
   output logic [CNT_W-1:0]      frame_lines,
   output logic                  capture_active
);
   localparam logic [7:0] WF = 8'(WAIT_FRAME);

   cap_state_t state, state_nxt;
   logic vs_d0, vs_d1, hr_d0, hr_d1, start_s, byte_flag, pix_vld;
   logic vs_pos, hr_neg, pix_done, meas, run;
   logic [CAM_BYTE_W-1:0] data_d0, high_byte;
   logic [7:0] skip_cnt;
   logic [CNT_W-1:0] pix_cnt, line_cnt, line_cnt_inc;

   sync_2ff u_start_sync (.clk(cam_pclk), .rst(rst), .d(capture_start), .q(start_s));

   assign vs_pos = vs_d0 & ~vs_d1;
   assign hr_neg = ~hr_d0 & hr_d1;
   assign pix_done = hr_d0 & byte_flag;
   assign run = state == RUN;
   assign meas = state != IDLE;
   assign line_cnt_inc = (&line_cnt) ? line_cnt : line_cnt + CNT_W'(1);

   // Gating is combinational on the state so the RUN-entry edge already opens the outputs
   // and reset closes them without waiting for a clock.
   assign cmos_frame_vsync = run & vs_d1;
   assign cmos_frame_href = run & hr_d1;
   assign cmos_frame_valid = run & pix_vld;
   assign capture_active = run;

   always_comb
      state_nxt = (state == IDLE && start_s) ? SKIP :
                  (state == SKIP && vs_pos && skip_cnt == WF) ? RUN : state;

   always_ff @(posedge cam_pclk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_nxt;

   always_ff @(posedge cam_pclk or posedge rst)
      if (rst) begin
         {vs_d0, vs_d1, hr_d0, hr_d1} <= 4'b0000;
         data_d0 <= '0;
         high_byte <= '0;
         byte_flag <= 1'b0;
         pix_vld <= 1'b0;
         cmos_frame_data <= '0;
         skip_cnt <= '0;
      end else begin
         {vs_d1, vs_d0} <= {vs_d0, cam_vsync};
         {hr_d1, hr_d0} <= {hr_d0, cam_href};
         data_d0 <= cam_data;
         byte_flag <= hr_d0 & ~byte_flag;
         if (hr_d0 && !byte_flag) high_byte <= data_d0;
         pix_vld <= pix_done;
         if (pix_done) cmos_frame_data <= {high_byte, data_d0};
         skip_cnt <= (state == SKIP && vs_pos) ? ((skip_cnt == WF) ? 8'd0 : skip_cnt + 8'd1) : skip_cnt;
      end

   // A line ending on the same cycle as a vsync edge is counted before frame_lines latches.
   always_ff @(posedge cam_pclk or posedge rst)
      if (rst) begin
         pix_cnt <= '0;
         line_cnt <= '0;
         line_pixels <= '0;
         frame_lines <= '0;
      end else if (meas) begin
         if (hr_neg) begin
            line_pixels <= pix_cnt;
            pix_cnt <= '0;
         end else if (pix_done && !(&pix_cnt)) pix_cnt <= pix_cnt + CNT_W'(1);
         if (vs_pos) begin
            frame_lines <= hr_neg ? line_cnt_inc : line_cnt;
            line_cnt <= '0;
         end else if (hr_neg) line_cnt <= line_cnt_inc;
      end
endmodule

// File: tb/tb_cmos_capture_data.sv
// tb_cmos_capture_data: randomized frames checked against a frame/pixel scoreboard,
// plus table-driven pairing vectors and hand-written reset and saturation sequences.
module tb_cmos_capture_data;
   localparam int WF = 2;
   localparam int LP_MAX = 8191;

   typedef struct { logic [7:0] hi; logic [7:0] lo; logic [15:0] exp; } vec_t;

   logic clk = 1'b0, rst = 1'b1, capture_start = 1'b0, cam_vsync = 1'b0, cam_href = 1'b0;
   logic [7:0] cam_data = 8'h00;
   logic fv, fh, fval, act, fv2, fh2, fval2, act2;
   logic [15:0] fdata, fdata2;
   logic [12:0] lp, fl;
   logic [3:0] lp2, fl2;

   int n_vec = 0, n_err = 0, cyc = 0;
   int n_strobe = 0, exp_frame_pix = 0, lines_in_frame = 0, prev_lines = 0, edges = 0;
   bit armed = 1'b0, out_en = 1'b0, mon_off = 1'b0;
   logic [15:0] exp_q[$], cap[$];
   int lo_q[$], cap_cyc[$];
   logic [7:0] lb[$];
   vec_t tbl[4];

   cmos_capture_data #(.WAIT_FRAME(WF), .CNT_W(13)) dut (
      .cam_pclk(clk), .rst(rst), .capture_start(capture_start), .cam_vsync(cam_vsync),
      .cam_href(cam_href), .cam_data(cam_data), .cmos_frame_vsync(fv), .cmos_frame_href(fh),
      .cmos_frame_valid(fval), .cmos_frame_data(fdata), .line_pixels(lp), .frame_lines(fl),
      .capture_active(act));

   cmos_capture_data #(.WAIT_FRAME(0), .CNT_W(4)) dut_sat (
      .cam_pclk(clk), .rst(rst), .capture_start(capture_start), .cam_vsync(cam_vsync),
      .cam_href(cam_href), .cam_data(cam_data), .cmos_frame_vsync(fv2), .cmos_frame_href(fh2),
      .cmos_frame_valid(fval2), .cmos_frame_data(fdata2), .line_pixels(lp2), .frame_lines(fl2),
      .capture_active(act2));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   task automatic check(input string name, input int act_v, input int exp_v);
      n_vec++;
      if (act_v !== exp_v) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act_v, exp_v);
      end
   endtask

   task automatic drive(input logic vs, input logic hr, input logic [7:0] d);
      @(posedge clk);
      #1;
      cam_vsync = vs;
      cam_href = hr;
      cam_data = d;
   endtask

   // Every pair of bytes becomes one pixel if the frame is meant to be output.
   task automatic send_line(input int n);
      for (int i = 0; i < n; i++) begin
         drive(1'b0, 1'b1, lb[i]);
         if (out_en && i % 2 == 1) begin
            exp_q.push_back({lb[i-1], lb[i]});
            lo_q.push_back(cyc);
            exp_frame_pix++;
         end
      end
      repeat (5) drive(1'b0, 1'b0, 8'h00);
      if (armed) begin
         check("line_pixels", lp, (n / 2 > LP_MAX) ? LP_MAX : n / 2);
         lines_in_frame++;
      end
   endtask

   task automatic send_frame(input int nl, input int nb, input bit use_tbl);
      n_strobe = 0;
      exp_frame_pix = 0;
      cap.delete();
      cap_cyc.delete();
      if (armed) begin
         edges++;
         out_en = edges > WF;
      end
      repeat (3) drive(1'b1, 1'b0, 8'h00);
      repeat (3) drive(1'b0, 1'b0, 8'h00);
      if (armed) begin
         check("frame_lines", fl, prev_lines);
         check("capture_active", act, out_en);
      end
      lines_in_frame = 0;
      for (int l = 0; l < nl; l++) begin
         lb.delete();
         if (use_tbl) foreach (tbl[i]) begin
            lb.push_back(tbl[i].hi);
            lb.push_back(tbl[i].lo);
         end
         else for (int i = 0; i < nb; i++) lb.push_back(8'($urandom));
         send_line(use_tbl ? 8 : nb);
      end
      repeat (3) drive(1'b0, 1'b0, 8'h00);
      check("frame_strobes", n_strobe, exp_frame_pix);
      prev_lines = armed ? lines_in_frame : 0;
   endtask

   always @(negedge clk) if (!mon_off) begin
      if (!out_en && (fval || fh || fv)) begin
         n_err++;
         $display("FAIL gating: vsync/href/valid=%b%b%b outside an output frame, expected 000", fv, fh, fval);
      end
      if (fval) begin
         n_strobe++;
         cap.push_back(fdata);
         cap_cyc.push_back(cyc);
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL extra_strobe: got pixel 0x%0h, expected no strobe", fdata);
         end else begin
            check("pix_data", fdata, exp_q.pop_front());
            check("pix_latency", cyc - lo_q.pop_front(), 2);
         end
      end
   end

   initial begin
      tbl[0] = '{8'hA5, 8'h5A, 16'hA55A};
      tbl[1] = '{8'hFF, 8'h00, 16'hFF00};
      tbl[2] = '{8'h12, 8'h34, 16'h1234};
      tbl[3] = '{8'h00, 8'hFF, 16'h00FF};
      repeat (3) @(posedge clk);
      #1;
      check("rst_vsync", fv, 0);
      check("rst_href", fh, 0);
      check("rst_valid", fval, 0);
      check("rst_data", fdata, 0);
      check("rst_line_pixels", lp, 0);
      check("rst_frame_lines", fl, 0);
      check("rst_active", act, 0);
      rst = 1'b0;
      repeat (3) send_frame(2, 8, 1'b0);
      check("idle_active", act, 0);
      check("idle_line_pixels", lp, 0);
      capture_start = 1'b1;
      repeat (5) drive(1'b0, 1'b0, 8'h00);
      armed = 1'b1;
      repeat (4) send_frame(4, 8, 1'b0);
      send_frame(1, 8, 1'b1);
      check("pair_count", cap.size(), 4);
      for (int i = 0; i < 4 && i < cap.size(); i++) check("pair_data_tbl", cap[i], tbl[i].exp);
      if (cap_cyc.size() >= 2) check("pair_gap", cap_cyc[1] - cap_cyc[0], 2);
      send_frame(1, 7, 1'b0);
      send_frame(5, 1280, 1'b0);
      send_frame(1, 40, 1'b0);
      check("sat_line_pixels", lp2, 15);
      capture_start = 1'b0;
      send_frame(3, 10, 1'b0);
      check("start_drop_active", act, 1);
      capture_start = 1'b1;
      mon_off = 1'b1;
      drive(1'b0, 1'b1, 8'($urandom));
      drive(1'b0, 1'b1, 8'($urandom));
      drive(1'b0, 1'b1, 8'($urandom));
      check("pre_reset_href", fh, 1);
      #2;
      rst = 1'b1;
      #1;
      check("midrst_vsync", fv, 0);
      check("midrst_href", fh, 0);
      check("midrst_valid", fval, 0);
      check("midrst_data", fdata, 0);
      check("midrst_line_pixels", lp, 0);
      check("midrst_active", act, 0);
      out_en = 1'b0;
      armed = 1'b0;
      edges = 0;
      prev_lines = 0;
      exp_q.delete();
      lo_q.delete();
      repeat (3) drive(1'b0, 1'b0, 8'h00);
      rst = 1'b0;
      repeat (5) drive(1'b0, 1'b0, 8'h00);
      mon_off = 1'b0;
      armed = 1'b1;
      repeat (WF + 1) send_frame(2, 8, 1'b0);
      check("final_active", act, 1);
      check("queue_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
